// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the phase-counter width calculation.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Counter must hold phase_length-1 for the longer of the two phases.
  function automatic int unsigned cnt_width(input int unsigned on_c,
                                            input int unsigned off_c);
    int unsigned m;
    int unsigned w;
    m = (on_c > off_c) ? on_c : off_c;
    w = unsigned'($clog2(m));
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches one-tick event strobes into fixed-width output pulses with a
// guaranteed low gap; events during a pulse queue in a saturating counter.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 1_000_000,
  parameter int unsigned OFF_CYCLES = 1_000_000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr_dropped,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              dropped
);

  localparam int unsigned       CW       = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [CW-1:0]     ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0]     OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || PEND_W < 1) begin : g_param_check
    $error("pulse_stretch: ON_CYCLES, OFF_CYCLES and PEND_W must be >= 1");
  end

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              dropped_nx;
  logic              inc;
  logic              drop_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      dropped <= 1'b0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pend_nx;
      dropped <= dropped_nx;
      out     <= (state_nx == ON);
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == ON) && (cnt_nx == ON_LAST);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pending;
    inc      = 1'b0;
    drop_ev  = 1'b0;

    unique case (state)
      IDLE: begin
        if (trig) begin
          state_nx = ON;
          cnt_nx   = '0;
        end
      end
      ON: begin
        inc = trig;
        if (cnt == ON_LAST) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      OFF: begin
        if (cnt == OFF_LAST) begin
          cnt_nx = '0;
          // A trig here either starts the next pulse directly (queue empty)
          // or cancels against the dequeue, so pending never increments.
          if (pending != '0 || trig) begin
            state_nx = ON;
            if (pending != '0 && !trig) pend_nx = pending - 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
          inc    = trig;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (inc) begin
      if (pending == PEND_MAX) drop_ev = 1'b1;
      else                     pend_nx = pending + 1'b1;
    end

    if (drop_ev)          dropped_nx = 1'b1;
    else if (clr_dropped) dropped_nx = 1'b0;
    else                  dropped_nx = dropped;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: a pulse-schedule model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_pulse_stretch;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PW   = 2;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          clr_dropped = 1'b0;
  logic          out, busy, done, dropped;
  logic [PW-1:0] pending;

  typedef struct packed {
    logic          out;
    logic          busy;
    logic          done;
    logic [PW-1:0] pending;
    logic          dropped;
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  bit   mdropped = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pulse_stretch #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .PEND_W    (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .clr_dropped(clr_dropped),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .pending    (pending),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  // Outputs for cycle c follow from the list of pulse start cycles accepted
  // from events in earlier cycles.
  function automatic exp_t model_expect(int c);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    foreach (starts[i]) begin
      if (starts[i] <= c && c < starts[i] + ON)       e.out  = 1'b1;
      if (c == starts[i] + ON - 1)                    e.done = 1'b1;
      if (starts[i] <= c && c < starts[i] + ON + OFF) e.busy = 1'b1;
      if (starts[i] > c) n++;
    end
    e.pending = PW'(n);
    e.dropped = mdropped;
    return e;
  endfunction

  // An event in cycle c starts at c+1 or one full period after the last
  // scheduled pulse; a deferred event is lost if the queue is already full.
  task automatic model_apply(input bit t, input bit c_clr, input int c);
    bit drop;
    int last;
    int st;
    int n;
    drop = 1'b0;
    if (t) begin
      last = (starts.size() > 0) ? starts[starts.size()-1] : -100;
      st   = (c + 1 > last + ON + OFF) ? c + 1 : last + ON + OFF;
      if (st > c + 1) begin
        n = 0;
        foreach (starts[i]) if (starts[i] > c + 1) n++;
        if (n == PMAX) drop = 1'b1;
        else           starts.push_back(st);
      end else begin
        starts.push_back(st);
      end
    end
    mdropped = drop ? 1'b1 : (c_clr ? 1'b0 : mdropped);
  endtask

  task automatic step(input bit r, input bit t, input bit c);
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      starts.delete();
      mdropped = 1'b0;
    end
    sb.push_back(model_expect(cyc));
    rst_n       = r;
    trig        = t;
    clr_dropped = c;
    if (r) model_apply(t, c, cyc);
    if (!r) begin
      #1;
      checks++;
      if ({out, busy, done, pending, dropped} !== '0) begin
        errors++;
        $display("FAIL async_reset cycle %0d: got out=%b busy=%b done=%b pending=%0d dropped=%b, want all 0",
                 cyc, out, busy, done, pending, dropped);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({out, busy, done, pending, dropped} !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got out=%b busy=%b done=%b pending=%0d dropped=%b, want out=%b busy=%b done=%b pending=%0d dropped=%b",
                 cyc, out, busy, done, pending, dropped,
                 e.out, e.busy, e.done, e.pending, e.dropped);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(3);

    // single event
    step(1'b1, 1'b1, 1'b0);
    idle(12);

    // two back-to-back events
    repeat (2) step(1'b1, 1'b1, 1'b0);
    idle(20);

    // held trig overflows the queue
    repeat (5) step(1'b1, 1'b1, 1'b0);
    idle(30);

    // overflow coinciding with clear, then clear alone
    repeat (4) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(30);

    // second event in the last OFF cycle
    step(1'b1, 1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 1'b0);
    idle(15);

    // reset mid-ON with one event pending, trig ignored while in reset
    repeat (2) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(12);

    // random traffic with occasional clears and resets
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 149) == 0)
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'b1, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    idle(40);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
